// File: rtl/xdma_pkg.sv
// Shared XDMA types: outbound data-accompany config and the grant receiver state encoding.
package xdma_pkg;

  typedef struct packed {
    logic dma_type;           // 1 = remote write
    logic ready_to_transfer;
  } to_remote_data_accompany_cfg_t;

  typedef enum logic [1:0] {
    StIdle,
    StWaitGrant,
    StStream,
    StWaitFinish
  } xdma_grant_state_e;

endpackage

// File: rtl/xdma_grant_credit_counter.sv
// Saturating up/down counter banking grants returned by the next hop.
module xdma_grant_credit_counter #(
  parameter int unsigned MaxCount = 2,
  parameter int unsigned Width    = $clog2(MaxCount + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic             full_o,
  output logic             nonzero_o
);

  localparam logic [Width-1:0] MaxVal = Width'(MaxCount);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != MaxVal)) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign full_o    = (count_q == MaxVal);
  assign nonzero_o = (count_q != '0);

endmodule

// File: rtl/xdma_grant_receiver.sv
// Gates an outbound remote-write data stream until a grant from the next hop is held;
// early grants are banked as credits.
module xdma_grant_receiver
  import xdma_pkg::*;
#(
  parameter int unsigned MaxCredits   = 2,
  parameter int unsigned BeatCntWidth = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  to_remote_data_accompany_cfg_t to_remote_data_accompany_cfg_i,
  input  logic                          from_remote_grant_valid_i,
  output logic                          from_remote_grant_ready_o,
  input  logic                          data_valid_i,
  output logic                          data_ready_o,
  input  logic                          data_last_i,
  output logic                          data_valid_o,
  input  logic                          data_ready_i,
  output logic [BeatCntWidth-1:0]       beat_count_o,
  output logic                          busy_o
);

  localparam int unsigned CreditW = $clog2(MaxCredits + 1);

  xdma_grant_state_e       state_q;
  logic [BeatCntWidth-1:0] beat_q;
  logic [CreditW-1:0]      credit_count;
  logic                    credit_full, credit_nonzero;
  logic                    need_grant, rtt, grant_hs, consume, passing, out_hs;

  assign rtt        = to_remote_data_accompany_cfg_i.ready_to_transfer;
  assign need_grant = to_remote_data_accompany_cfg_i.dma_type & rtt;

  // Ready depends only on the registered count, so a full bank stays closed even while consuming.
  assign from_remote_grant_ready_o = ~credit_full;
  assign grant_hs                  = from_remote_grant_valid_i & ~credit_full;

  always_comb begin
    consume = 1'b0;
    case (state_q)
      StIdle:      consume = need_grant & credit_nonzero;
      StWaitGrant: consume = rtt & credit_nonzero;
      default:     consume = 1'b0;
    endcase
  end

  xdma_grant_credit_counter #(
    .MaxCount (MaxCredits),
    .Width    (CreditW)
  ) u_credit (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .inc_i     (grant_hs),
    .dec_i     (consume),
    .count_o   (credit_count),
    .full_o    (credit_full),
    .nonzero_o (credit_nonzero)
  );

  // Non-remote-write traffic bypasses the gate entirely while idle.
  assign passing      = (state_q == StStream) |
                        ((state_q == StIdle) & ~to_remote_data_accompany_cfg_i.dma_type);
  assign data_valid_o = passing & data_valid_i;
  assign data_ready_o = passing & data_ready_i;
  assign out_hs       = (state_q == StStream) & data_valid_i & data_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      beat_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (need_grant) begin
            if (credit_nonzero) begin
              state_q <= StStream;
              beat_q  <= '0;
            end else begin
              state_q <= StWaitGrant;
            end
          end
        end
        StWaitGrant: begin
          if (!rtt) begin
            state_q <= StIdle;
          end else if (credit_nonzero) begin
            state_q <= StStream;
            beat_q  <= '0;
          end
        end
        StStream: begin
          if (out_hs) begin
            beat_q <= beat_q + 1'b1;
            if (data_last_i) state_q <= StWaitFinish;
          end
        end
        StWaitFinish: begin
          if (!rtt) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign beat_count_o = beat_q;
  assign busy_o       = (state_q != StIdle);

  credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    credit_count <= CreditW'(MaxCredits));

endmodule

// File: tb/tb_xdma_grant_receiver.sv
// Self-checking bench for xdma_grant_receiver: vector table, corner sequences, random vs model.
module tb_xdma_grant_receiver;
  import xdma_pkg::*;

  localparam int unsigned MaxC = 2;
  localparam int unsigned Bw   = 16;

  logic clk_i = 1'b0;
  logic rst_ni;
  to_remote_data_accompany_cfg_t cfg;
  logic gv, gr, dv_i, dr_o, last, dv_o, dr_i, busy;
  logic [Bw-1:0] beats;

  int n_tests = 0;
  int n_fail  = 0;

  xdma_grant_receiver #(
    .MaxCredits   (MaxC),
    .BeatCntWidth (Bw)
  ) dut (
    .clk_i                          (clk_i),
    .rst_ni                         (rst_ni),
    .to_remote_data_accompany_cfg_i (cfg),
    .from_remote_grant_valid_i      (gv),
    .from_remote_grant_ready_o      (gr),
    .data_valid_i                   (dv_i),
    .data_ready_o                   (dr_o),
    .data_last_i                    (last),
    .data_valid_o                   (dv_o),
    .data_ready_i                   (dr_i),
    .beat_count_o                   (beats),
    .busy_o                         (busy)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic gv, dma, rtt, dv, dr, last;
    logic gr, dvo, dro, busy;
    int   beats;
    int   credit;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic g, input logic dma, input logic r, input logic v,
                       input logic rd, input logic l);
    gv = g; cfg.dma_type = dma; cfg.ready_to_transfer = r; dv_i = v; dr_i = rd; last = l;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
  endtask

  function automatic int credit_now();
    return int'(dut.credit_count);
  endfunction

  // Reference model: transfer phases as flags, credit as a plain integer.
  int m_credit, m_beats;
  bit m_wait, m_stream, m_fin;

  task automatic model_step();
    bit idle, take;
    idle = !(m_wait || m_stream || m_fin);
    take = 0;
    if (idle) begin
      if (cfg.dma_type && cfg.ready_to_transfer) begin
        if (m_credit > 0) begin take = 1; m_stream = 1; m_beats = 0; end
        else m_wait = 1;
      end
    end else if (m_wait) begin
      if (!cfg.ready_to_transfer) m_wait = 0;
      else if (m_credit > 0) begin take = 1; m_wait = 0; m_stream = 1; m_beats = 0; end
    end else if (m_stream) begin
      if (dv_i && dr_i) begin
        m_beats = (m_beats + 1) % (1 << Bw);
        if (last) begin m_stream = 0; m_fin = 1; end
      end
    end else if (!cfg.ready_to_transfer) begin
      m_fin = 0;
    end
    m_credit = m_credit + ((gv && m_credit < MaxC) ? 1 : 0) - (take ? 1 : 0);
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    //          gv dma rtt dv dr last | gr dvo dro busy beats credit
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1};
    tbl[3]  = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 0};
    tbl[5]  = '{0, 1, 0, 0, 1, 0, 1, 0, 1, 1, 2, 0};
    tbl[6]  = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 2, 0};
    tbl[7]  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 3, 0};
    tbl[8]  = '{0, 1, 1, 1, 1, 0, 1, 0, 0, 1, 4, 0};
    tbl[9]  = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 4, 0};
    tbl[10] = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 4, 0};
    tbl[11] = '{0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 4, 0};
    tbl[12] = '{0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 4, 0};
    tbl[13] = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 4, 0};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].gv, tbl[i].dma, tbl[i].rtt, tbl[i].dv, tbl[i].dr, tbl[i].last);
      #1;
      check($sformatf("vec%0d.grant_ready", i), gr, tbl[i].gr);
      check($sformatf("vec%0d.data_valid_o", i), dv_o, tbl[i].dvo);
      check($sformatf("vec%0d.data_ready_o", i), dr_o, tbl[i].dro);
      check($sformatf("vec%0d.busy", i), busy, tbl[i].busy);
      check($sformatf("vec%0d.beats", i), beats, tbl[i].beats);
      check($sformatf("vec%0d.credit", i), credit_now(), tbl[i].credit);
      tick();
    end

    // Transfer first: five idle-waiting cycles, then one grant; stream two cycles later.
    do_reset();
    drive(0, 1, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      #1 check("wait.no_valid", dv_o, 0);
      tick();
    end
    check("wait.busy", busy, 1);
    gv = 1'b1;
    #1 check("wait.grant_ready", gr, 1);
    tick();
    gv = 1'b0;
    #1 check("wait.n1_no_valid", dv_o, 0);
    check("wait.n1_credit", credit_now(), 1);
    tick();
    #1 check("wait.n2_valid", dv_o, 1);
    check("wait.n2_credit", credit_now(), 0);

    // Saturation: three grants back-to-back, bypass keeps credits untouched.
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    #1 check("sat.ready0", gr, 1);
    tick();
    #1 check("sat.ready1", gr, 1);
    tick();
    #1 check("sat.ready2", gr, 0);
    check("sat.credit_full", credit_now(), 2);
    cfg.dma_type = 1'b1; cfg.ready_to_transfer = 1'b1;
    #1 check("sat.ready_while_consume", gr, 0);
    tick();
    #1 check("sat.ready_after", gr, 1);
    check("sat.credit_after", credit_now(), 1);
    check("sat.stream", busy, 1);
    tick();
    gv = 1'b0;
    #1 check("sat.third_taken", credit_now(), 2);

    // Simultaneous grant and consume.
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 1, 1, 0);
    #1 check("sim.pre_credit", credit_now(), 1);
    tick();
    gv = 1'b0;
    #1 check("sim.credit", credit_now(), 1);
    check("sim.stream_valid", dv_o, 1);

    // Abort in WAIT_GRANT, then banked grant gives 1-cycle start.
    do_reset();
    drive(0, 1, 1, 0, 0, 0);
    tick();
    #1 check("abort.wait_busy", busy, 1);
    cfg.ready_to_transfer = 1'b0;
    tick();
    gv = 1'b1;
    #1 check("abort.idle", busy, 0);
    tick();
    gv = 1'b0;
    #1 check("abort.credit", credit_now(), 1);
    check("abort.still_idle", busy, 0);
    drive(0, 1, 1, 1, 1, 0);
    tick();
    #1 check("abort.restart_valid", dv_o, 1);
    tick();
    tick();
    #1 check("abort.beats", beats, 2);

    // Asynchronous reset mid-stream.
    #2 rst_ni = 1'b0;
    #1;
    check("rst.ready", gr, 1);
    check("rst.valid", dv_o, 0);
    check("rst.dready", dr_o, 0);
    check("rst.busy", busy, 0);
    check("rst.beats", beats, 0);
    check("rst.credit", credit_now(), 0);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;

    // Randomized run against the reference model.
    do_reset();
    m_credit = 0; m_beats = 0; m_wait = 0; m_stream = 0; m_fin = 0;
    drive(0, 1, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      bit m_idle;
      gv = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) cfg.dma_type = ~cfg.dma_type;
      if ($urandom_range(0, 11) == 0) cfg.ready_to_transfer = ~cfg.ready_to_transfer;
      dv_i = $urandom_range(0, 1);
      dr_i = $urandom_range(0, 1);
      last = ($urandom_range(0, 4) == 0);
      #1;
      m_idle = !(m_wait || m_stream || m_fin);
      check("rnd.grant_ready", gr, (m_credit < MaxC));
      check("rnd.data_valid_o", dv_o, (m_stream || (m_idle && !cfg.dma_type)) && dv_i);
      check("rnd.data_ready_o", dr_o, (m_stream || (m_idle && !cfg.dma_type)) && dr_i);
      check("rnd.busy", busy, !m_idle);
      check("rnd.beats", beats, m_beats);
      check("rnd.credit", credit_now(), m_credit);
      model_step();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xdma_grant_receiver.md
# xdma_grant_receiver

Sender-side counterpart of the XDMA grant handshake. When the local XDMA pushes a remote-write data stream to the next hop, this block consumes grants returned by that hop and gates the outgoing data stream until one grant is held. Grants may arrive before the local transfer is configured; they are banked as credits. Sits between the local data-stream source and the outbound remote-data channel, driven by the to-remote data-accompany configuration.

## Interface
- `to_remote_data_accompany_cfg_t`, default `logic`: config struct type; fields used: `dma_type` (1 = remote write), `ready_to_transfer`.
- `MaxCredits`, default 2: banked-grant capacity, ≥1.
- `BeatCntWidth`, default 16: width of the beat counter.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `to_remote_data_accompany_cfg_i`  in  struct  current outbound transfer config.
- `from_remote_grant_valid_i`  in  1  grant from next hop.
- `from_remote_grant_ready_o`  out  1  grant accepted when credit space is free.
- `data_valid_i` / `data_ready_o` / `data_last_i`  in/out/in  1 each  local data stream.
- `data_valid_o` / `data_ready_i`  out/in  1 each  outbound data stream.
- `beat_count_o`  out  BeatCntWidth  beats sent in the current transfer.
- `busy_o`  out  1  state ≠ IDLE.

## Operation
- `need_grant` = `dma_type == 1` && `ready_to_transfer`.
- Credit counter, range 0..MaxCredits:
  - +1 on a grant handshake.
  - −1 on consume.
  - Both in the same cycle: count unchanged.
- `from_remote_grant_ready_o` = (credit < MaxCredits), from the registered count only.
- States:
  - IDLE:
    - `need_grant` && credit > 0: consume → STREAM.
    - `need_grant` && credit == 0: → WAIT_GRANT.
  - WAIT_GRANT:
    - `ready_to_transfer` == 0: → IDLE, nothing consumed (abort).
    - else if credit > 0: consume → STREAM.
  - STREAM:
    - `data_valid_o = data_valid_i`.
    - `data_ready_o = data_ready_i`.
    - Beat counter increments on each outbound handshake.
    - Handshake with `data_last_i`: → WAIT_FINISH.
  - WAIT_FINISH: `ready_to_transfer` == 0 → IDLE.
- Outside STREAM, `data_valid_o` = 0 and `data_ready_o` = 0.
- Exception: when `dma_type == 0`, the block passes data through with no gating, no credit use, and stays in IDLE.
- Beat counter:
  - Clears on the IDLE→STREAM transition.
  - Holds its value through WAIT_FINISH.
  - Wraps modulo 2^BeatCntWidth.
- Consumption only uses the registered credit count. A grant accepted in the same cycle is not consumable that cycle.

## Timing
- Reset values:
  - state IDLE, credit 0.
  - `from_remote_grant_ready_o` = 1.
  - `data_valid_o`, `data_ready_o`, `busy_o` = 0.
  - `beat_count_o` = 0.
- Latency with credit banked: `need_grant` rises at cycle N, STREAM at N+1, first beat possible at N+1.
- Latency with no credit: grant handshake at cycle N in WAIT_GRANT, credit = 1 at N+1, consumed at N+1, STREAM at N+2.
- Credit full (== MaxCredits): `from_remote_grant_ready_o` = 0 even if a consume occurs that cycle; ready returns the following cycle.
- `data_*` paths in STREAM are combinational pass-through, no added latency.
- Any state, reset asserted: immediate return to reset values. Banked credits are lost.
- `ready_to_transfer` dropping in STREAM is ignored until the last beat. The FSM completes the stream.

## Structure
- `to_remote_data_accompany_cfg_t` and the state enum (IDLE, WAIT_GRANT, STREAM, WAIT_FINISH) live in the shared `xdma_pkg`.
- Sub-module `xdma_grant_credit_counter`: saturating up/down counter with `inc_i`, `dec_i`, `count_o`, `full_o`, `nonzero_o`.
- FSM, data gating and beat counter stay in the top module.

## Test plan
- Grant first, then transfer:
  - Stimulus: one grant at idle (credit 0→1); `dma_type=1`, `ready_to_transfer=1`; 4-beat stream with last on beat 4.
  - Required: STREAM next cycle; `beat_count_o` = 4; WAIT_FINISH; IDLE after `ready_to_transfer` falls; credit 0.
- Transfer first:
  - Stimulus: `need_grant` held 5 cycles with no grant, then one grant.
  - Required: no `data_valid_o` during the wait; STREAM exactly 2 cycles after the grant handshake.
- Credit saturation (MaxCredits = 2):
  - Stimulus: 3 grants offered back-to-back.
  - Required: first two accepted; ready low on the third; after one consume, ready high the next cycle and the third is accepted.
- Simultaneous grant and consume:
  - Stimulus: credit = 1, IDLE with `need_grant`, grant handshake in the same cycle.
  - Required: credit stays 1 and the FSM enters STREAM.
- Abort in WAIT_GRANT:
  - Stimulus: `ready_to_transfer` drops in WAIT_GRANT, then a grant arrives.
  - Required: IDLE with credit = 1; a later transfer starts with 1-cycle latency.
- Bypass and reset:
  - Stimulus: `dma_type=0`, 3 beats; then reset asserted mid-STREAM.
  - Required: bypass beats pass with no credit change; on reset, all outputs return to reset values and credit = 0.
